// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: arbiter state encodings, master-select
// encoding and the slave address map used by decoder and bus muxes.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    // Master-select encoding driven onto the bus muxes.
    localparam logic SEL_M0 = 1'b0;
    localparam logic SEL_M1 = 1'b1;

    // Slave address map.
    localparam logic [7:0] S0_BASE  = 8'h00;
    localparam logic [7:0] S1_BASE  = 8'h20;
    localparam logic [7:0] WIN_SIZE = 8'h20;

    // Burst counter width; a single-cycle burst still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a burst limit.
// Ports: clk, reset (sync, active-high), m0_req, m1_req in;
//        m0_grant, m1_grant, m_sel, busy out (from state only).
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic m0_req,
    input  logic m1_req,
    output logic m0_grant,
    output logic m1_grant,
    output logic m_sel,
    output logic busy
);

    localparam int CNT_W = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(MAX_BURST - 1);

    state_t           state;
    state_t           state_nx;
    logic             last;
    logic [CNT_W-1:0] burst_cnt;

    logic at_limit;
    assign at_limit = (burst_cnt == CNT_MAX);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    (m0_req && !m1_req): state_nx = GRANT0;
                    (!m0_req && m1_req): state_nx = GRANT1;
                    // Tie goes to whoever was not served last.
                    (m0_req && m1_req):
                        state_nx = (last == SEL_M1) ? GRANT0
                                                    : GRANT1;
                    default: state_nx = IDLE;
                endcase
            end
            GRANT0: begin
                if (!m0_req)
                    state_nx = m1_req ? GRANT1 : IDLE;
                else if (m1_req && at_limit)
                    state_nx = GRANT1;
            end
            GRANT1: begin
                if (!m1_req)
                    state_nx = m0_req ? GRANT0 : IDLE;
                else if (m0_req && at_limit)
                    state_nx = GRANT0;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The counter runs during solo ownership too, so a long
    // owner saturates and yields as soon as a competitor appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= SEL_M1;
            burst_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                burst_cnt <= '0;
                if (state_nx == GRANT0)
                    last <= SEL_M0;
                else if (state_nx == GRANT1)
                    last <= SEL_M1;
            end else if (state != IDLE && !at_limit) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end
    end

    // IDLE parks the bus on master 0.
    assign m0_grant = (state == GRANT0);
    assign m1_grant = (state == GRANT1);
    assign m_sel    = m1_grant ? SEL_M1 : SEL_M0;
    assign busy     = m0_grant | m1_grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised and directed bench for bus_arbiter (MAX_BURST 4 and 1)
// against an ownership/run-length reference model.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m0_req = 1'b0;
    logic m1_req = 1'b0;
    logic a_g0, a_g1, a_sel, a_busy;
    logic b_g0, b_g1, b_sel, b_busy;

    int checks = 0;
    int failures = 0;

    // Model: owner 0 = none, 1 = master 0, 2 = master 1.
    int own[2];
    int held[2];
    int lst[2];
    int mbv[2];

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_BURST(4)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_grant(a_g0), .m1_grant(a_g1),
        .m_sel(a_sel), .busy(a_busy)
    );

    bus_arbiter #(.MAX_BURST(1)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_grant(b_g0), .m1_grant(b_g1),
        .m_sel(b_sel), .busy(b_busy)
    );

    function automatic logic [3:0] got(input int k);
        if (k == 0) return {a_g0, a_g1, a_sel, a_busy};
        return {b_g0, b_g1, b_sel, b_busy};
    endfunction

    function automatic logic [3:0] expv(input int k);
        if (own[k] == 1) return 4'b1001;
        if (own[k] == 2) return 4'b0111;
        return 4'b0000;
    endfunction

    task automatic model_edge(input bit r0, input bit r1,
                              input bit rs);
        bit req[2];
        int nxt, o, oth;
        req[0] = r0;
        req[1] = r1;
        for (int k = 0; k < 2; k++) begin
            if (rs) begin
                own[k] = 0; held[k] = 0; lst[k] = 1;
            end else begin
                if (own[k] == 0) begin
                    if (r0 && r1) nxt = (lst[k] == 1) ? 1 : 2;
                    else if (r0) nxt = 1;
                    else if (r1) nxt = 2;
                    else nxt = 0;
                end else begin
                    o = own[k] - 1;
                    oth = 1 - o;
                    if (!req[o])
                        nxt = req[oth] ? oth + 1 : 0;
                    else if (req[oth] && held[k] >= mbv[k])
                        nxt = oth + 1;
                    else
                        nxt = own[k];
                end
                if (nxt != own[k]) begin
                    held[k] = (nxt != 0) ? 1 : 0;
                    if (nxt != 0) lst[k] = nxt - 1;
                end else if (own[k] != 0) begin
                    held[k]++;
                end
                own[k] = nxt;
            end
        end
    endtask

    // Drive, take one edge, update the model, settle.
    task automatic step(input bit r0, input bit r1, input bit rs);
        m0_req = r0;
        m1_req = r1;
        reset = rs;
        @(posedge clk);
        model_edge(r0, r1, rs);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 1);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got(k) !== 4'b0000) begin
                    failures++;
                    $display("FAIL reset[%0d] dut%0d got=%b exp=0000",
                             i, k, got(k));
                end
            end
        end
        step(1, 1, 0);
        checks++;
        if (got(0) !== 4'b1001 || got(0) !== expv(0)) begin
            failures++;
            $display("FAIL reset_release got=%b exp=1001", got(0));
        end
    endtask

    task automatic test_solo();
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            checks++;
            if (got(0) !== 4'b0111 || got(1) !== expv(1)) begin
                failures++;
                $display("FAIL solo[%0d] got=%b/%b exp=0111/%b",
                         i, got(0), got(1), expv(1));
            end
        end
        step(0, 0, 0);
        checks++;
        if (got(0) !== 4'b0000 || got(1) !== 4'b0000) begin
            failures++;
            $display("FAIL solo_release got=%b/%b exp=0000",
                     got(0), got(1));
        end
    endtask

    task automatic test_contention();
        logic [3:0] ea, eb;
        step(0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0);
            ea = (i < 4 || i >= 8) ? 4'b1001 : 4'b0111;
            eb = (i % 2 == 0) ? 4'b1001 : 4'b0111;
            checks++;
            if (got(0) !== ea || got(1) !== eb) begin
                failures++;
                $display("FAIL contend[%0d] got=%b/%b exp=%b/%b",
                         i, got(0), got(1), ea, eb);
            end
        end
        step(0, 0, 0);
    endtask

    task automatic test_handoff();
        step(1, 0, 0);
        step(1, 1, 0);
        step(0, 1, 0);
        checks++;
        if (got(0) !== 4'b0111 || got(0) !== expv(0)) begin
            failures++;
            $display("FAIL handoff got=%b exp=0111", got(0));
        end
        step(0, 0, 0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        checks++;
        if (got(0) !== 4'b1001) begin
            failures++;
            $display("FAIL sat_solo got=%b exp=1001", got(0));
        end
        step(1, 1, 0);
        checks++;
        if (got(0) !== 4'b0111 || got(1) !== 4'b0111) begin
            failures++;
            $display("FAIL sat_yield got=%b/%b exp=0111",
                     got(0), got(1));
        end
        step(0, 0, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        step(1, 1, 1);
        checks++;
        if (got(0) !== 4'b0000 || got(1) !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid got=%b/%b exp=0000",
                     got(0), got(1));
        end
        step(1, 1, 0);
        checks++;
        if (got(0) !== 4'b1001 || got(1) !== 4'b1001) begin
            failures++;
            $display("FAIL rst_mid_tie got=%b/%b exp=1001",
                     got(0), got(1));
        end
        step(0, 0, 0);
    endtask

    task automatic test_random();
        bit r0, r1, rs;
        for (int i = 0; i < 400; i++) begin
            r0 = ($urandom_range(3, 0) != 0);
            r1 = ($urandom_range(3, 0) != 0);
            rs = ($urandom_range(39, 0) == 0);
            step(r0, r1, rs);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got(k) !== expv(k)) begin
                    failures++;
                    $display("FAIL rand[%0d] dut%0d got=%b exp=%b",
                             i, k, got(k), expv(k));
                end
            end
            checks++;
            if ((a_g0 & a_g1) !== 1'b0 || (b_g0 & b_g1) !== 1'b0)
            begin
                failures++;
                $display("FAIL mutex[%0d] got=%b%b/%b%b exp=no overlap",
                         i, a_g0, a_g1, b_g0, b_g1);
            end
        end
    endtask

    initial begin
        mbv[0] = 4;
        mbv[1] = 1;
        for (int k = 0; k < 2; k++) begin
            own[k] = 0; held[k] = 0; lst[k] = 1;
        end
        test_reset();
        test_solo();
        test_contention();
        test_handoff();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
